mem_bus_arb: RTL

Sequencer and arbiter for the single shared memory bus of the br32 core. It grants the bus to the instruction-fetch port or the data port, one outstanding transaction at a time. The data port is driven by the EX/MEM register fields: `mem_r`/`mem_w`, `mem_sz`, `mem_sx`, `alu_res` as address and `op3` as store data. For the data port the block performs byte-lane steering, byte-enable generation, misalignment detection and load extraction with sign or zero extension.

---
 rtl/mem_bus_arb.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arb.sv
// Shared memory bus sequencer: arbitrates fetch and data ports, one transaction at a time.
// Data port adds lane steering, byte enables, misalignment trapping and load extension.
module mem_bus_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_sz,
    input  logic        d_sx,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        kill_q, kill_d;
    logic        port_d_q, port_d_d;
    logic        err_q, err_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  sz_q, sz_d;
    logic        sx_q, sx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic        mis_c;
    logic [31:0] sh;
    logic [31:0] ld_ext;
    logic        unused_if_lo;

    assign unused_if_lo = ^if_addr[1:0];

    always_comb begin
        be_c  = 4'hF;
        wd_c  = d_wdata;
        mis_c = 1'b0;
        unique case (d_sz)
            2'd0: begin
                be_c = 4'b0001 << d_addr[1:0];
                wd_c = {4{d_wdata[7:0]}};
            end
            2'd1: begin
                be_c  = 4'b0011 << {d_addr[1], 1'b0};
                wd_c  = {2{d_wdata[15:0]}};
                mis_c = d_addr[0];
            end
            2'd2: mis_c = |d_addr[1:0];
            default: mis_c = 1'b1;
        endcase
    end

    // Load data uses the size/sign/offset captured at grant, not the live inputs.
    assign sh = bus_rdata >> {lo_q, 3'b000};

    always_comb begin
        ld_ext = sh;
        unique case (sz_q)
            2'd0: ld_ext = {{24{sx_q & sh[7]}}, sh[7:0]};
            2'd1: ld_ext = {{16{sx_q & sh[15]}}, sh[15:0]};
            default: ld_ext = sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        kill_d      = kill_q;
        port_d_d    = port_d_q;
        err_d       = err_q;
        lo_d        = lo_q;
        sz_d        = sz_q;
        sx_d        = sx_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !(if_req && last_d_q)) begin
                    last_d_d = 1'b1;
                    port_d_d = 1'b1;
                    kill_d   = 1'b0;
                    lo_d     = d_addr[1:0];
                    sz_d     = d_sz;
                    sx_d     = d_sx;
                    err_d    = mis_c;
                    if (mis_c) begin
                        rdata_d = 32'd0;
                        state_d = DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = d_we;
                        bus_addr_d  = {d_addr[31:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_wdata_d = wd_c;
                        state_d     = BUSY_D;
                    end
                end else if (if_req) begin
                    last_d_d    = 1'b0;
                    port_d_d    = 1'b0;
                    kill_d      = 1'b0;
                    err_d       = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {if_addr[31:2], 2'b00};
                    bus_be_d    = 4'hF;
                    bus_wdata_d = 32'd0;
                    state_d     = BUSY_I;
                end
            end
            BUSY_I: begin
                if (if_flush) kill_d = 1'b1;
                if (bus_ack) begin
                    rdata_d     = bus_rdata;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'd0;
                    bus_be_d    = 4'd0;
                    bus_wdata_d = 32'd0;
                    state_d     = DONE;
                end
            end
            BUSY_D: begin
                if (bus_ack) begin
                    rdata_d     = bus_we_q ? 32'd0 : ld_ext;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'd0;
                    bus_be_d    = 4'd0;
                    bus_wdata_d = 32'd0;
                    state_d     = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            kill_q      <= 1'b0;
            port_d_q    <= 1'b0;
            err_q       <= 1'b0;
            lo_q        <= 2'd0;
            sz_q        <= 2'd0;
            sx_q        <= 1'b0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            kill_q      <= kill_d;
            port_d_q    <= port_d_d;
            err_q       <= err_d;
            lo_q        <= lo_d;
            sz_q        <= sz_d;
            sx_q        <= sx_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // A flush landing in the completion cycle still suppresses the fetch result.
    assign if_valid  = (state_q == DONE) && !port_d_q && !kill_q && !if_flush;
    assign if_rdata  = rdata_q;
    assign d_done    = (state_q == DONE) && port_d_q;
    assign d_err     = d_done && err_q;
    assign d_rdata   = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
